// File: rtl/hsc_tdc_pkg.sv
// hsc_tdc_pkg: tap-chain geometry and code widths shared by the TDC core and its popcount
package hsc_tdc_pkg;
    localparam int TAPS = 127;
    localparam int HW_W = $clog2(TAPS + 1);
    localparam int PC_W = HW_W;
endpackage

// File: rtl/hsc_tdc_popcount.sv
// hsc_tdc_popcount: combinational Hamming weight of the TAPS-wide tap difference vector
module hsc_tdc_popcount
    import hsc_tdc_pkg::*;
(
    input  logic [TAPS-1:0] vec_i,
    output logic [PC_W-1:0] cnt_o
);
    // sum every tap bit; synthesis flattens this into an adder tree
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < TAPS; i++) cnt_o = cnt_o + PC_W'(vec_i[i]);
    end
endmodule

// File: rtl/hsc_tdc_core.sv
// hsc_tdc_core: single-clock TDC, launches pulse edge into a tap chain and codes it by popcount (optional ovf via HSC_TDC_OVF_EN)
module hsc_tdc_core
    import hsc_tdc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            launch,
    input  logic            capture,
    input  logic            pg_src,
    input  logic            pg_bypass,
    input  logic            pg_in,
    input  logic            pg_tog,
`ifdef HSC_TDC_OVF_EN
    output logic            ovf,
`endif
    output logic [HW_W-1:0] hw,
    output logic            hw_valid
);
    logic            sync_q;
    logic [TAPS-1:0] chain_q;
    logic            ref_q;
    logic [HW_W-1:0] hw_q;
    logic            valid_q;
    logic            raw;
    logic            pulse;
    logic [PC_W-1:0] pc;
`ifdef HSC_TDC_OVF_EN
    logic            ovf_q;
    assign ovf = ovf_q;
`endif

    assign raw      = pg_src ? pg_tog : pg_in;
    assign pulse    = pg_bypass ? raw : sync_q;
    assign hw       = hw_q;
    assign hw_valid = valid_q;

    hsc_tdc_popcount u_pc (
        .vec_i (chain_q ^ {TAPS{ref_q}}),
        .cnt_o (pc)
    );

    // capture compares the pre-edge chain against the old reference, so launch+capture uses the previous ref
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 1'b0;
            chain_q <= '0;
            ref_q   <= 1'b0;
            hw_q    <= '0;
            valid_q <= 1'b0;
`ifdef HSC_TDC_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= raw;
            chain_q <= {chain_q[TAPS-2:0], pulse};
            valid_q <= capture;
            if (launch) ref_q <= pulse;
            if (capture) begin
                hw_q <= HW_W'(pc);
`ifdef HSC_TDC_OVF_EN
                ovf_q <= (pc == PC_W'(TAPS));
`endif
            end
        end
    end
endmodule

// File: tb/tb_hsc_tdc_core.sv
// tb_hsc_tdc_core: directed and randomized checks of hsc_tdc_core against a pulse-history reference model
module tb_hsc_tdc_core;
    import hsc_tdc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic launch = 1'b0, capture = 1'b0, pg_src = 1'b0, pg_bypass = 1'b1, pg_in = 1'b0, pg_tog = 1'b0;
    logic [HW_W-1:0] hw;
    logic hw_valid;
`ifdef HSC_TDC_OVF_EN
    logic ovf;
`endif

    int checks = 0;
    int failures = 0;

    // reference model: history of pulse levels seen by the chain, newest first
    bit       m_hist[$];
    bit       m_sync, m_ref, m_valid, m_ovf;
    int       m_hw;

    hsc_tdc_core dut (
        .clk       (clk),
        .rst       (rst),
        .launch    (launch),
        .capture   (capture),
        .pg_src    (pg_src),
        .pg_bypass (pg_bypass),
        .pg_in     (pg_in),
        .pg_tog    (pg_tog),
`ifdef HSC_TDC_OVF_EN
        .ovf       (ovf),
`endif
        .hw        (hw),
        .hw_valid  (hw_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_hist = {};
        for (int i = 0; i < TAPS; i++) m_hist.push_back(1'b0);
        m_sync = 0; m_ref = 0; m_hw = 0; m_valid = 0; m_ovf = 0;
    endtask

    // one clock: model evaluates the pre-edge inputs, then outputs are compared 1 time unit after the edge
    task automatic tick();
        bit raw, pulse;
        int diff;
        raw   = pg_src ? pg_tog : pg_in;
        pulse = pg_bypass ? raw : m_sync;
        diff  = 0;
        foreach (m_hist[i]) if (m_hist[i] != m_ref) diff++;
        @(posedge clk);
        if (rst) model_clear();
        else begin
            m_valid = capture;
            if (capture) begin
                m_hw  = diff;
                m_ovf = (diff == TAPS);
            end
            if (launch) m_ref = pulse;
            m_sync = raw;
            m_hist.push_front(pulse);
            while (m_hist.size() > TAPS) void'(m_hist.pop_back());
        end
        #1;
        chk("hw", int'(hw), m_hw);
        chk("hw_valid", int'(hw_valid), int'(m_valid));
`ifdef HSC_TDC_OVF_EN
        chk("ovf", int'(ovf), int'(m_ovf));
`endif
    endtask

    task automatic do_reset();
        rst = 1; launch = 1; capture = 1; pg_in = 1;
        repeat (2) tick();
        rst = 0; launch = 0; capture = 0; pg_in = 0;
    endtask

    initial begin
        model_clear();
        // reset with strobes asserted; a following capture proves the chain and ref are zero
        do_reset();
        chk("rst_hw", int'(hw), 0);
        chk("rst_valid", int'(hw_valid), 0);
        capture = 1; tick(); capture = 0;
        chk("rst_chain_hw", int'(hw), 0);
        chk("rst_chain_valid", int'(hw_valid), 1);

        // bypass edge, capture at E10
        do_reset();
        pg_bypass = 1; pg_src = 0; pg_in = 0; launch = 1; tick(); launch = 0;
        pg_in = 1; repeat (10) tick();
        capture = 1; tick(); capture = 0;
        chk("t2_hw", int'(hw), 10);
        chk("t2_valid", int'(hw_valid), 1);
        tick();
        chk("t2_valid_drop", int'(hw_valid), 0);
        chk("t2_hold", int'(hw), 10);

        // synchronised path adds one cycle
        do_reset();
        pg_bypass = 0; pg_in = 0; launch = 1; tick(); launch = 0;
        pg_in = 1; repeat (10) tick();
        capture = 1; tick(); capture = 0;
        chk("t3_hw", int'(hw), 9);

        // toggle source runs past the last tap and saturates
        do_reset();
        pg_src = 1; pg_bypass = 1; pg_tog = 0; launch = 1; tick(); launch = 0;
        pg_tog = 1; repeat (200) tick();
        capture = 1; tick(); capture = 0;
        chk("t4_hw", int'(hw), TAPS);
`ifdef HSC_TDC_OVF_EN
        chk("t4_ovf", int'(ovf), 1);
`endif

        // falling edge against ref=1
        do_reset();
        pg_src = 0; pg_bypass = 1; pg_in = 1; repeat (130) tick();
        launch = 1; tick(); launch = 0;
        pg_in = 0; repeat (5) tick();
        capture = 1; tick(); capture = 0;
        chk("t5_hw", int'(hw), 5);

        // launch+capture together uses old ref, next capture sees new ref
        do_reset();
        pg_in = 0; launch = 1; tick(); launch = 0;
        pg_in = 1; repeat (10) tick();
        launch = 1; capture = 1; tick(); launch = 0;
        chk("t6_old_ref", int'(hw), 10);
        tick(); capture = 0;
        chk("t6_new_ref", int'(hw), TAPS - 11);
        chk("t6_b2b_valid", int'(hw_valid), 1);

        // randomized traffic including glitching source/bypass changes and mid-run resets
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) pg_in = ~pg_in;
            pg_tog = ~pg_tog;
            if ($urandom_range(0, 99) < 3) pg_src = ~pg_src;
            if ($urandom_range(0, 99) < 3) pg_bypass = ~pg_bypass;
            launch  = ($urandom_range(0, 99) < 5);
            capture = ($urandom_range(0, 99) < 15);
            rst     = ($urandom_range(0, 999) < 4);
            tick();
        end
        rst = 0; launch = 0; capture = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
